// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Optional checksum trailer (and its CSUM state) is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    S_CSUM  = 3'd7
`endif
  } state_e;

  // A frame is accepted only for 1..max_words words; zero-length and oversize images are errors.
  function automatic logic len_ok(input logic [LEN_W-1:0] n, input int max_words);
    return (n != '0) && (int'(n) <= max_words);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = the loader (consumes bytes, drives imem writes); slave = stream source / imem side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into words: first byte lands in bits [7:0].
// word_full flags the cycle whose accepted byte completes a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [BCNT_W-1:0] cnt;

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (take) begin
      cnt  <= cnt + 1'b1;
      word <= {din, word[WORD_W-1:8]};
    end
  end

  assign word_full = take && (cnt == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames LEN_LO, LEN_HI, N little-endian words into imem; holds the core in reset
// until the image is complete. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.master bus,
  output logic         core_rst,
  output logic         done,
  output logic         err
);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] word;
  logic              rdy, fire, take, word_full, start_ok, last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  assign rdy = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
`else
  assign rdy = state_q inside {S_LEN0, S_LEN1, S_DATA};
`endif

  assign fire      = bus.byte_valid && rdy;
  assign take      = fire && (state_q == S_DATA);
  assign start_ok  = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign last_word = (word_cnt_q == len_q - 1'b1);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .take      (take),
    .din       (bus.byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        word_cnt_q <= '0;
        addr_q     <= '0;
      end
      if (state_q == S_LEN0 && fire) len_lo_q <= bus.byte_data;
      if (state_q == S_LEN1 && fire) len_q    <= {bus.byte_data, len_lo_q};
      // Address is captured on entry to WRITE and then held until the next word completes.
      if (word_full) addr_q <= ADDR_W'(word_cnt_q);
      if (state_q == S_WRITE) word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (take)     csum_q <= csum_q ^ bus.byte_data;
  end
`endif

  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    core_rst = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    bus.imem_we = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LEN0;
      S_LEN0:  if (fire)  state_d = S_LEN1;
      S_LEN1: begin
        if (fire) state_d = len_ok({bus.byte_data, len_lo_q}, MAX_WORDS) ? S_DATA : S_ERR;
      end
      S_DATA:  if (word_full) state_d = S_WRITE;
      S_WRITE: begin
        bus.imem_we = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_d = last_word ? S_CSUM : S_DATA;
`else
        state_d = last_word ? S_DONE : S_DATA;
`endif
      end
      S_DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
        if (start) state_d = S_LEN0;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_d = S_LEN0;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:  if (fire) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byte_ready = rdy;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected imem writes are queued as frames are sent and
// popped by a write monitor. Covers the checksum trailer when IMEM_LOADER_CHECKSUM_EN is set.
module tb_imem_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic core_rst, done, err;

  int vectors     = 0;
  int miscompares = 0;
  int writes_seen = 0;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] words[$];
  logic [7:0]  frame_xor;
`ifdef IMEM_LOADER_CHECKSUM_EN
  bit          corrupt_csum = 1'b0;
`endif

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  // Write monitor: each imem_we cycle must match the oldest queued write and never accept a byte.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      writes_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr=%0h data=%08h, no write was queued",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== {mon_e.addr, mon_e.data}) begin
          miscompares++;
          $display("FAIL imem_write: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                   bus.imem_addr, bus.imem_wdata, mon_e.addr, mon_e.data);
        end
      end
      vectors++;
      if (bus.byte_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_in_write: byte_ready=%b, expected 0", bus.byte_ready);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout: byte_ready=%b, expected 1 within 40 cycles", bus.byte_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    if (with_byte) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
    end
    @(posedge clk);
    #1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
  endtask

  // Sends the frame held in words[], queuing one expected write per word.
  task automatic send_frame(input bit hold);
    logic [15:0] n;
    logic [31:0] w;
    wr_t         e;
    n         = 16'(words.size());
    frame_xor = 8'h00;
    send_byte(n[7:0], hold);
    send_byte(n[15:8], hold);
    for (int i = 0; i < words.size(); i++) begin
      w      = words[i];
      e.addr = ADDR_W'(i);
      e.data = w;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], hold);
        frame_xor = frame_xor ^ w[8*k +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(corrupt_csum ? (frame_xor ^ 8'h01) : frame_xor, hold);
`endif
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done=%b err=%b, expected one of them within 40 cycles",
               tag, done, err);
    end
  endtask

  task automatic expect_done(input string tag);
    vectors++;
    if ({done, err, core_rst} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s_status: done/err/core_rst=%b, expected 100", tag, {done, err, core_rst});
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending: %0d queued writes never seen, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst, done, err}
        !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: ready=%b we=%b addr=%0h wdata=%08h core_rst=%b done=%b err=%b, expected 0 0 0 00000000 1 0 0",
               bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst, done, err);
    end
    rst = 1'b1;
  endtask

  task automatic test_nominal;
    // start together with a byte in IDLE: the byte must not be consumed
    pulse_start(1'b1, 8'hFF);
    words.delete();
    words.push_back(32'h0050_0013);
    words.push_back(32'h00A0_0093);
    send_frame(1'b0);
    wait_end("nominal");
    expect_done("nominal");
  endtask

  task automatic test_zero_len;
    int w0;
    w0 = writes_seen;
    pulse_start(1'b0, 8'h00);
    vectors++;
    if ({done, core_rst} !== 2'b01) begin
      miscompares++;
      $display("FAIL restart_from_done: done/core_rst=%b, expected 01", {done, core_rst});
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    vectors++;
    if ({err, done, core_rst} !== 3'b101 || writes_seen != w0) begin
      miscompares++;
      $display("FAIL zero_len: err/done/core_rst=%b writes=%0d, expected 101 writes=0",
               {err, done, core_rst}, writes_seen - w0);
    end
  endtask

  task automatic test_oversize;
    int w0;
    w0 = writes_seen;
    pulse_start(1'b0, 8'h00);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_from_err: err=%b, expected 0", err);
    end
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    vectors++;
    if ({err, core_rst} !== 2'b11 || writes_seen != w0) begin
      miscompares++;
      $display("FAIL oversize: err/core_rst=%b writes=%0d, expected 11 writes=0",
               {err, core_rst}, writes_seen - w0);
    end
    pulse_start(1'b0, 8'h00);
    words.delete();
    words.push_back(32'hCAFE_F00D);
    send_frame(1'b0);
    wait_end("after_err");
    expect_done("after_err");
  endtask

  // Full-size image with byte_valid held high throughout; WRITE cycles are the only stalls.
  task automatic test_back_to_back;
    int w0;
    w0 = writes_seen;
    pulse_start(1'b0, 8'h00);
    words.delete();
    for (int i = 0; i < MAX_WORDS; i++) words.push_back((32'(i) * 32'h0001_0103) ^ 32'hA5C3_5A3C);
    send_frame(1'b1);
    wait_end("max_len");
    expect_done("max_len");
    vectors++;
    if (writes_seen - w0 != MAX_WORDS) begin
      miscompares++;
      $display("FAIL max_len_count: writes=%0d, expected %0d", writes_seen - w0, MAX_WORDS);
    end
  endtask

  task automatic test_start_ignored;
    wr_t e;
    pulse_start(1'b0, 8'h00);
    e.addr = '0;
    e.data = 32'h1234_5678;
    exp_q.push_back(e);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    pulse_start(1'b0, 8'h00);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12, 1'b0);
`endif
    wait_end("start_ignored");
    expect_done("start_ignored");
  endtask

  task automatic test_reset_mid_load;
    pulse_start(1'b0, 8'h00);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst, done, err}
        !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_load_reset: ready=%b we=%b addr=%0h wdata=%08h core_rst=%b done=%b err=%b, expected 0 0 0 00000000 1 0 0",
               bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst, done, err);
    end
    @(negedge clk);
    rst = 1'b1;
    pulse_start(1'b0, 8'h00);
    words.delete();
    words.push_back(32'h0050_0013);
    send_frame(1'b0);
    wait_end("reload");
    expect_done("reload");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    pulse_start(1'b0, 8'h00);
    words.delete();
    words.push_back(32'h0050_0013);
    send_frame(1'b0);
    wait_end("csum_good");
    vectors++;
    if (frame_xor !== 8'h43) begin
      miscompares++;
      $display("FAIL csum_model: bench checksum=%02h, expected 43", frame_xor);
    end
    expect_done("csum_good");
    corrupt_csum = 1'b1;
    pulse_start(1'b0, 8'h00);
    send_frame(1'b0);
    corrupt_csum = 1'b0;
    wait_end("csum_bad");
    vectors++;
    if ({err, done, core_rst} !== 3'b101 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL csum_bad: err/done/core_rst=%b pending_writes=%0d, expected 101 pending=0",
               {err, done, core_rst}, exp_q.size());
      exp_q.delete();
    end
  endtask
`endif

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_nominal();
    test_zero_len();
    test_oversize();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
